ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//   Requester side of the instruction-memory interface: owns the fetch PC, drives imem address,
//   captures combinational-read data into a small prefetch FIFO and presents {pc, instr} to decode
//   over a valid/ready handshake. Supports PC redirect (branch/jump) with flush and misalignment trap.
// PARAMETERS
//   RESET_PC    32'h0000_0000  fetch PC loaded on reset; must be word-aligned
//   FIFO_DEPTH  2              prefetch entries; power of 2, >=2
// PORTS
//   clk             in   1   rising-edge clock
//   rst             in   1   asynchronous, active-high reset
//   imem_a          out  32  instruction memory byte address (= fetch_pc, combinational from reg)
//   imem_rd         in   32  instruction word, combinational read of imem_a, same cycle
//   redirect_valid  in   1   load new fetch PC this cycle, flush FIFO
//   redirect_pc     in   32  target byte address
//   inst_valid      out  1   head FIFO entry valid
//   inst_ready      in   1   decode accepts head entry
//   inst            out  32  head instruction word
//   inst_pc         out  32  byte address of head instruction
//   misalign_err    out  1   sticky: last redirect target had pc[1:0]!=0
// BEHAVIOUR
//   Reset (async, immediate): fetch_pc=RESET_PC, FIFO count=0, state=FETCH, inst_valid=0, inst=0,
//     inst_pc=0, misalign_err=0; imem_a=RESET_PC while rst high.
//   States: FETCH (normal), HALT (misaligned target; no fetching).
//   pop  = inst_valid & inst_ready.
//   push = state==FETCH & ~redirect_valid & (count<FIFO_DEPTH | pop); pushes {fetch_pc, imem_rd}
//     sampled at the edge; fetch_pc <= fetch_pc+4 on push (mod 2^32: 0xFFFF_FFFC -> 0).
//   No push -> fetch_pc and imem_a hold.
//   Simultaneous push+pop at full: allowed, count unchanged, order preserved.
//   Latency: word at imem_a pushed at edge N appears on inst/inst_pc after edge N if FIFO was empty
//     (1 cycle); first inst_valid=1 one cycle after rst deasserts.
//   Throughput: 1 instr/cycle with inst_ready held high.
//   Outputs inst/inst_pc are the registered head entry; hold stable while inst_valid & ~inst_ready.
//   inst/inst_pc hold last value when empty (don't-care, not zeroed).
//   Redirect priority: redirect_valid beats push and pop; FIFO count <= 0 (pop that cycle discarded).
//     aligned target:    fetch_pc<=redirect_pc, state<=FETCH, misalign_err<=0.
//     misaligned target: fetch_pc<={redirect_pc[31:2],2'b00}, state<=HALT, misalign_err<=1.
//   HALT: no push, inst_valid=0, imem_a holds; exits only via aligned redirect (-> FETCH).
//     Misaligned redirect in HALT stays HALT, err stays 1.
//   After redirect: next cycle inst_valid=0; target instruction valid the cycle after.
//   Reset mid-stream: all FIFO contents lost, no partial entries; resumes from RESET_PC.
// TESTING
//   Bench imem: rd = {16'hA5A5, a[15:0]}, combinational.
//   1 Reset release, inst_ready=1 -> inst_pc 0,4,8,12,16,20 on consecutive cycles,
//     inst=0xA5A5_0000,...,0xA5A5_0014.
//   2 inst_ready=0 for 5 cycles after reset -> FIFO holds pc 0,4; imem_a held at 8;
//     then ready=1 -> 0,4,8,12 in order, no loss/dup.
//   3 FIFO full (pc 0,4), redirect_valid=1 pc=0x100 with inst_ready=1 same cycle ->
//     next cycle inst_valid=0, then inst_pc=0x100, 0x104; pc 0/4 never reappear.
//   4 Redirect 0x102 -> misalign_err=1, inst_valid=0 for 10 cycles, imem_a=0x100;
//     redirect 0x200 -> err=0, inst_pc=0x200 two cycles later.
//   5 RESET_PC=32'hFFFF_FFF8 -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
//   6 rst pulsed between edges mid-stream -> inst_valid=0 and imem_a=RESET_PC before next edge;
//     stream restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads imem combinationally and
// queues {pc, instr} pairs in a small prefetch FIFO toward decode.
//
// state   | meaning
// FETCH   | normal sequential fetch, pushing one word per cycle when space allows
// HALT    | last redirect target was misaligned; no fetching until an aligned redirect
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HALT  = 1'b1;

  logic [31:0]   fetch_pc;
  logic [0:0]    state;
  logic [31:0]   pc_mem  [FIFO_DEPTH];
  logic [31:0]   ins_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          push;

  assign imem_a     = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst       = ins_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];
  assign pop        = inst_valid & inst_ready;
  // A pop frees a slot in the same edge, so a full FIFO still accepts a word.
  assign push       = (state == S_FETCH) & ~redirect_valid & ((count < DEPTH) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      state        <= S_FETCH;
      misalign_err <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc     <= redirect_pc;
        state        <= S_FETCH;
        misalign_err <= 1'b0;
      end else begin
        fetch_pc     <= {redirect_pc[31:2], 2'b00};
        state        <= S_HALT;
        misalign_err <= 1'b1;
      end
    end else begin
      if (push) begin
        pc_mem[wr_ptr]  <= fetch_pc;
        ins_mem[wr_ptr] <= imem_rd;
        wr_ptr          <= wr_ptr + AW'(1);
        fetch_pc        <= fetch_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: queue-based scoreboard of expected fetch PCs,
// one task per scenario, plus a second instance exercising PC wrap-around.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign_err;

  logic        rst2;
  logic [31:0] imem_a2;
  logic [31:0] imem_rd2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        inst_valid2;
  logic        inst_ready2;
  logic [31:0] inst2;
  logic [31:0] inst_pc2;
  logic        misalign_err2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q  [$];
  logic [31:0] wrap_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rd  = {16'hA5A5, imem_a[15:0]};
  assign imem_rd2 = {16'hA5A5, imem_a2[15:0]};

  ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_a(imem_a), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .misalign_err(misalign_err)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst(rst2), .imem_a(imem_a2), .imem_rd(imem_rd2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst(inst2),
    .inst_pc(inst_pc2), .misalign_err(misalign_err2)
  );

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int budget;
    logic [31:0] e;
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
        imem_a !== 32'h0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b inst=%h pc=%h imem_a=%h err=%b, required 0 0 0 0 0",
               inst_valid, inst, inst_pc, imem_a, misalign_err);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    rst = 1'b0;
    // With ready high every cycle must deliver the next word.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== e || inst !== {16'hA5A5, e[15:0]}) begin
        errors++;
        $display("FAIL stream_after_reset[%0d]: valid=%b pc=%h inst=%h, required 1 %h %h",
                 i, inst_valid, inst_pc, inst, e, {16'hA5A5, e[15:0]});
      end
    end
    budget = 0;
  endtask

  task automatic test_stall();
    int budget;
    logic [31:0] e;
    inst_ready = 1'b0;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'hA5A5_0000) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h inst=%h, required 1 00000000 a5a50000",
                 i, inst_valid, inst_pc, inst);
      end
    end
    checks++;
    if (imem_a !== 32'h8) begin
      errors++;
      $display("FAIL stall_imem_a: imem_a=%h, required 00000008", imem_a);
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    inst_ready = 1'b1;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      if (inst_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (inst_pc !== e || inst !== {16'hA5A5, e[15:0]}) begin
          errors++;
          $display("FAIL stall_drain: pc=%h inst=%h, required %h %h",
                   inst_pc, inst, e, {16'hA5A5, e[15:0]});
        end
      end
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_redirect_flush();
    int budget;
    logic [31:0] e;
    inst_ready = 1'b0;
    pulse_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_a !== 32'h8) begin
      errors++;
      $display("FAIL flush_full: valid=%b pc=%h imem_a=%h, required 1 00000000 00000008",
               inst_valid, inst_pc, imem_a);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100; inst_ready = 1'b1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_a !== 32'h100) begin
      errors++;
      $display("FAIL flush_bubble: valid=%b imem_a=%h, required 0 00000100", inst_valid, imem_a);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_target_latency: valid=%b, required 1", inst_valid);
    end
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      if (inst_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (inst_pc !== e || inst !== {16'hA5A5, e[15:0]}) begin
          errors++;
          $display("FAIL flush_stream: pc=%h inst=%h, required %h %h",
                   inst_pc, inst, e, {16'hA5A5, e[15:0]});
        end
      end
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL flush_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (misalign_err !== 1'b1 || inst_valid !== 1'b0 || imem_a !== 32'h100) begin
      errors++;
      $display("FAIL misalign_enter: err=%b valid=%b imem_a=%h, required 1 0 00000100",
               misalign_err, inst_valid, imem_a);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b0 || imem_a !== 32'h100 || misalign_err !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold[%0d]: valid=%b imem_a=%h err=%b, required 0 00000100 1",
                 i, inst_valid, imem_a, misalign_err);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h303;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b1 || inst_valid !== 1'b0 || imem_a !== 32'h300) begin
      errors++;
      $display("FAIL halt_misalign_again: err=%b valid=%b imem_a=%h, required 1 0 00000300",
               misalign_err, inst_valid, imem_a);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (misalign_err !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_exit: err=%b valid=%b, required 0 0", misalign_err, inst_valid);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'hA5A5_0200) begin
      errors++;
      $display("FAIL halt_exit_target: valid=%b pc=%h inst=%h, required 1 00000200 a5a50200",
               inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_wrap();
    int budget;
    logic [31:0] e;
    wrap_q.push_back(32'hFFFF_FFF8); wrap_q.push_back(32'hFFFF_FFFC);
    wrap_q.push_back(32'h0000_0000); wrap_q.push_back(32'h0000_0004);
    @(negedge clk);
    checks++;
    if (imem_a2 !== 32'hFFFF_FFF8 || inst_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_reset: imem_a=%h valid=%b, required fffffff8 0", imem_a2, inst_valid2);
    end
    rst2 = 1'b0;
    @(negedge clk);
    budget = 10;
    while (wrap_q.size() > 0 && budget > 0) begin
      if (inst_valid2) begin
        e = wrap_q.pop_front();
        checks++;
        if (inst_pc2 !== e || inst2 !== {16'hA5A5, e[15:0]}) begin
          errors++;
          $display("FAIL wrap_stream: pc=%h inst=%h, required %h %h",
                   inst_pc2, inst2, e, {16'hA5A5, e[15:0]});
        end
      end
      @(negedge clk);
      budget--;
    end
    checks++;
    if (wrap_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_timeout: %0d entries left, required 0", wrap_q.size());
      wrap_q.delete();
    end
  endtask

  task automatic test_reset_midstream();
    int budget;
    logic [31:0] e;
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_a !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL midreset_async: valid=%b imem_a=%h inst=%h pc=%h, required 0 0 0 0",
               inst_valid, imem_a, inst, inst_pc);
    end
    #1 rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    @(negedge clk);
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      if (inst_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (inst_pc !== e || inst !== {16'hA5A5, e[15:0]}) begin
          errors++;
          $display("FAIL midreset_stream: pc=%h inst=%h, required %h %h",
                   inst_pc, inst, e, {16'hA5A5, e[15:0]});
        end
      end
      @(negedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst2 = 1'b1; inst_ready2 = 1'b1; redirect_valid2 = 1'b0; redirect_pc2 = '0;
    test_reset();
    test_stall();
    test_redirect_flush();
    test_misalign();
    test_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
